gpu_fetch_stage: RTL and testbench

Instruction-fetch stage of the Filter-GPU core, sitting directly upstream of the instruction memory. It owns the program counter and drives PC to imem together with the selected kernel code. It captures the combinational 28-bit Instr that imem returns into the IF/ID pipeline register, and it handles stall, branch redirect/flush and end-of-kernel sequencing with start/done handshakes to the filter controller.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/gpu_ifid_reg.sv | 37 +++
 rtl/gpu_fetch_stage.sv | 126 ++++++++++++
 tb/tb_gpu_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the Filter-GPU instruction-fetch stage.
package gpu_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 28;
  localparam int PROG_LEN    = 9;
  localparam int PC_STEP     = 4;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 28'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/gpu_ifid_reg.sv
// IF/ID pipeline register: flush beats hold; an enabled cycle without a new
// fetch turns the slot into a bubble.
module gpu_ifid_reg
  import gpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    pc_d,
  output logic                   valid_d
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d <= NOP_INSTR;
      pc_d    <= {PC_WIDTH{1'b0}};
      valid_d <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (en) begin
      if (load) begin
        instr_d <= instr_in;
        pc_d    <= pc_in;
        valid_d <= 1'b1;
      end else begin
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpu_fetch_stage.sv
// Instruction-fetch stage: owns the PC and kernel select, sequences a kernel
// from start through drain to done, and feeds the IF/ID register.
module gpu_fetch_stage
  import gpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             kernel_sel,
  input  logic                   pipe_empty,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] Instr,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [1:0]             kernel,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [PC_WIDTH-1:0]    pc_d,
  output logic                   valid_d,
  output logic                   busy,
  output logic                   done
);

  fetch_state_t          state_r;
  fetch_state_t          state_s;
  logic [PC_WIDTH-1:0]   pc_s;
  logic [PC_WIDTH-1:0]   target_s;
  logic                  target_ok_s;
  logic                  last_s;
  logic                  flush_s;
  logic                  load_s;
  logic                  start_ok_s;

  assign target_s    = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign target_ok_s = (branch_target >> 2) < PC_WIDTH'(PROG_LEN);
  assign last_s      = (PC >> 2) == PC_WIDTH'(PROG_LEN - 1);

  always_comb begin
    state_s    = state_r;
    pc_s       = PC;
    flush_s    = 1'b0;
    load_s     = 1'b0;
    start_ok_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        pc_s = {PC_WIDTH{1'b0}};
        if (start) begin
          state_s    = FETCH;
          start_ok_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        if (branch_taken) begin
          flush_s = 1'b1;
          // An out-of-range redirect ends the kernel rather than fetching garbage.
          if (target_ok_s) begin
            pc_s = target_s;
          end else begin
            state_s = DRAIN;
          end
        end else if (stall) begin
          pc_s = PC;
        end else begin
          load_s = 1'b1;
          if (last_s) begin
            state_s = DRAIN;
          end else begin
            pc_s = PC + PC_WIDTH'(PC_STEP);
          end
        end
      end
      DRAIN: begin
        flush_s = branch_taken;
        if (branch_taken && target_ok_s) begin
          state_s = FETCH;
          pc_s    = target_s;
        end else if (!valid_d && pipe_empty) begin
          state_s = DONE;
          pc_s    = {PC_WIDTH{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
        pc_s    = {PC_WIDTH{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      PC      <= {PC_WIDTH{1'b0}};
      kernel  <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      PC      <= pc_s;
      busy    <= (state_s == FETCH) || (state_s == DRAIN);
      if (start_ok_s) begin
        kernel <= kernel_sel;
        done   <= 1'b0;
      end else if ((state_r == DRAIN) && (state_s == DONE)) begin
        done <= 1'b1;
      end
    end
  end

  gpu_ifid_reg u_ifid (
    .clk      (clk),
    .reset    (reset),
    .en       (!stall),
    .flush    (flush_s),
    .load     (load_s),
    .instr_in (Instr),
    .pc_in    (PC),
    .instr_d  (instr_d),
    .pc_d     (pc_d),
    .valid_d  (valid_d)
  );

endmodule

// File: tb/tb_gpu_fetch_stage.sv
// Bench for gpu_fetch_stage: directed vector table, then random stimulus,
// all cross-checked every cycle against a kernel-level reference model.
module tb_gpu_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, start, pipe_empty, stall, branch_taken;
  logic [1:0]  kernel_sel;
  logic [31:0] branch_target;
  logic [27:0] Instr;
  logic [31:0] PC, pc_d;
  logic [1:0]  kernel;
  logic [27:0] instr_d;
  logic        valid_d, busy, done;

  logic [27:0] mem [0:8];
  int checks = 0;
  int failures = 0;

  // reference model: mode 0 idle, 1 fetching, 2 draining, 3 done
  int          m_mode;
  int unsigned m_pc, m_pcd;
  logic [27:0] m_instr;
  logic [1:0]  m_kernel;
  bit          m_valid, m_done;

  typedef struct {
    bit rst; bit st; logic [1:0] ks; bit stl; bit br; logic [31:0] tgt; bit pe;
    int e_pc; int e_pcd; bit e_v; bit e_busy; bit e_done; logic [1:0] e_k;
  } vec_t;
  vec_t tv[$];

  always #5 clk = ~clk;

  always_comb begin
    if (PC[31:2] < 30'd9) Instr = mem[PC[5:2]];
    else Instr = 28'h0;
  end

  gpu_fetch_stage dut (
    .clk(clk), .reset(reset), .start(start), .kernel_sel(kernel_sel),
    .pipe_empty(pipe_empty), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .Instr(Instr), .PC(PC), .kernel(kernel),
    .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit st, input logic [1:0] ks, input bit stl,
                              input bit br, input logic [31:0] tgt, input bit pe);
    int unsigned tw;
    bit old_valid;
    tw = tgt >> 2;
    old_valid = m_valid;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_kernel = 2'b00; m_instr = 28'h0; m_pcd = 0;
      m_valid = 1'b0; m_done = 1'b0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (st) begin m_mode = 1; m_kernel = ks; m_done = 1'b0; end
    end else if (m_mode == 1) begin
      if (br) begin
        m_instr = 28'h0; m_valid = 1'b0;
        if (tw >= 9) m_mode = 2;
        else m_pc = tgt & 32'hFFFF_FFFC;
      end else if (!stl) begin
        m_instr = mem[m_pc / 4]; m_pcd = m_pc; m_valid = 1'b1;
        if (m_pc / 4 == 8) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      if (br) begin m_instr = 28'h0; m_valid = 1'b0; end
      else if (!stl) m_valid = 1'b0;
      if (br && tw < 9) begin m_mode = 1; m_pc = tgt & 32'hFFFF_FFFC; end
      else if (!old_valid && pe) begin m_mode = 3; m_done = 1'b1; m_pc = 0; end
    end
  endtask

  task automatic step(input bit rst, input bit st, input logic [1:0] ks, input bit stl,
                      input bit br, input logic [31:0] tgt, input bit pe);
    reset = rst; start = st; kernel_sel = ks; stall = stl;
    branch_taken = br; branch_target = tgt; pipe_empty = pe;
    model_update(rst, st, ks, stl, br, tgt, pe);
    @(posedge clk);
    #1;
    check("model_pc", PC, m_pc);
    check("model_kernel", 32'(kernel), 32'(m_kernel));
    check("model_valid", 32'(valid_d), 32'(m_valid));
    check("model_instr", 32'(instr_d), 32'(m_instr));
    if (m_valid) check("model_pcd", pc_d, m_pcd);
    check("model_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    check("model_done", 32'(done), 32'(m_done));
  endtask

  task automatic add(input bit rst, input bit st, input logic [1:0] ks, input bit stl, input bit br,
                     input logic [31:0] tgt, input bit pe, input int e_pc, input int e_pcd,
                     input bit e_v, input bit e_busy, input bit e_done, input logic [1:0] e_k);
    vec_t v;
    v.rst = rst; v.st = st; v.ks = ks; v.stl = stl; v.br = br; v.tgt = tgt; v.pe = pe;
    v.e_pc = e_pc; v.e_pcd = e_pcd; v.e_v = e_v; v.e_busy = e_busy; v.e_done = e_done; v.e_k = e_k;
    tv.push_back(v);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; kernel_sel = 2'b00; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; pipe_empty = 1'b0;
    for (int i = 0; i < 9; i++) mem[i] = 28'($urandom);

    //   rst st ks    stl br tgt     pe   pc  pcd v  bsy dn k
    add(1, 0, 2'd0, 0, 0, 32'h0,  0,   0,  0, 0, 0, 0, 2'd0);
    add(0, 1, 2'd1, 0, 0, 32'h0,  0,   0,  0, 0, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   4,  0, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   8,  4, 1, 1, 0, 2'd1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 2'd0, 1, 0, 32'h0, 0,  8,  4, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,  12,  8, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,  16, 12, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 1, 1, 32'h6,  0,   4,  0, 0, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   8,  4, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,  12,  8, 1, 1, 0, 2'd1);
    add(0, 1, 2'd2, 0, 0, 32'h0,  0,  16, 12, 1, 1, 0, 2'd1);
    for (int a = 20; a <= 32; a += 4)
      add(0, 0, 2'd0, 0, 0, 32'h0, 0,  a, a - 4, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,  32, 32, 1, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  1,  32,  0, 0, 1, 0, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  1,   0,  0, 0, 0, 1, 2'd1);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   0,  0, 0, 0, 1, 2'd1);
    add(0, 1, 2'd3, 0, 0, 32'h0,  0,   0,  0, 0, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 1, 32'h20, 0,  32,  0, 0, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,  32, 32, 1, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 1, 32'h0,  1,   0,  0, 0, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   4,  0, 1, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 1, 32'h40, 0,   4,  0, 0, 1, 0, 2'd3);
    add(0, 0, 2'd0, 0, 1, 32'h40, 1,   0,  0, 0, 0, 1, 2'd3);
    add(0, 1, 2'd1, 0, 0, 32'h0,  0,   0,  0, 0, 1, 0, 2'd1);
    for (int a = 4; a <= 20; a += 4)
      add(0, 0, 2'd0, 0, 0, 32'h0, 0,  a, a - 4, 1, 1, 0, 2'd1);
    add(1, 0, 2'd0, 0, 0, 32'h0,  0,   0,  0, 0, 0, 0, 2'd0);
    add(0, 0, 2'd0, 0, 0, 32'h0,  0,   0,  0, 0, 0, 0, 2'd0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].st, tv[i].ks, tv[i].stl, tv[i].br, tv[i].tgt, tv[i].pe);
      check($sformatf("vec%0d_pc", i), PC, 32'(tv[i].e_pc));
      check($sformatf("vec%0d_valid", i), 32'(valid_d), 32'(tv[i].e_v));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(tv[i].e_done));
      check($sformatf("vec%0d_kernel", i), 32'(kernel), 32'(tv[i].e_k));
      if (tv[i].e_v) begin
        check($sformatf("vec%0d_pcd", i), pc_d, 32'(tv[i].e_pcd));
        check($sformatf("vec%0d_instr", i), 32'(instr_d), 32'(mem[tv[i].e_pcd / 4]));
      end
    end

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, 2'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
           32'($urandom_range(0, 48)), $urandom_range(0, 99) < 50);
    end

    // Let any kernel in flight finish; the completion wait is bounded.
    step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1);
        seen = (done === 1'b1);
      end
      check("final_done_within_budget", 32'(seen), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
